rect_fill_engine: RTL and testbench
===================================

// Module: rect_fill_engine
// PURPOSE
// - Parametrised framebuffer fill engine: writes one colour to every pixel of a rectangle, one pixel/clk.
// - Generalises the full-screen black-out sweep to any rectangle, colour and resolution.
// - Sits between the drawing client (line animator) and VGA_framebuffer write port.
// - Client writes pass through when idle; fills take priority when busy.
// PARAMETERS
// - WIDTH    640  visible columns; x range 0..WIDTH-1
// - HEIGHT   480  visible rows; y range 0..HEIGHT-1
// - COORD_W  11   coordinate bus width; must hold max(WIDTH,HEIGHT)-1
// - COLOR_W  1    pixel colour width
// PORTS
// - clk           in   1        system clock (CLOCK_50)
// - reset_n       in   1        synchronous, active-low reset
// - start         in   1        request fill; sampled only in IDLE
// - x0, y0        in   COORD_W  rectangle top-left, inclusive
// - x1, y1        in   COORD_W  rectangle bottom-right, inclusive
// - fill_color    in   COLOR_W  fill colour
// - busy          out  1        high while FILL or DONE
// - done          out  1        one-cycle pulse after the last fill write
// - cl_x, cl_y    in   COORD_W  client pixel coordinate
// - cl_color      in   COLOR_W  client colour
// - cl_write      in   1        client write strobe
// - cl_ready      out  1        client writes accepted (state==IDLE)
// - fb_x, fb_y    out  COORD_W  framebuffer write coordinate
// - fb_color      out  COLOR_W  framebuffer write colour
// - fb_write      out  1        framebuffer write strobe
// BEHAVIOUR
// - Reset is synchronous and active-low: reset_n==0 at a clk edge sets state IDLE.
// - Reset values: fb_x=0, fb_y=0, fb_color=0, fb_write=0, busy=0, done=0, cl_ready=0.
// - After reset, the first IDLE cycle registers cl_ready=1.
// - All outputs are registered.
// - IDLE:
//   - fb_* <= cl_* each cycle, giving 1-cycle pass-through latency.
//   - fb_write <= cl_write only when cl_x<WIDTH and cl_y<HEIGHT; out-of-range writes are dropped.
//   - start=1 latches the clamped rectangle and fill_color. Clamp: x1c=min(x1,WIDTH-1), y1c=min(y1,HEIGHT-1).
//   - Then go to FILL. The same-cycle client write is dropped, and cl_ready drops.
// - Empty rectangle (x0>x1c or y0>y1c, or x0>=WIDTH, or y0>=HEIGHT): IDLE->DONE directly, with zero writes.
// - FILL:
//   - Raster order; the first write (x0,y0) appears on fb_* the cycle after start was sampled.
//   - x increments each clk; at x==x1c, x wraps to x0 and y increments.
//   - The write at (x1c,y1c) is the last; next state is DONE.
//   - Exactly (x1c-x0+1)*(y1c-y0+1) consecutive fb_write cycles.
// - DONE: one cycle with done=1, fb_write=0; then IDLE.
// - Ignored while busy: start, cl_* inputs, and changes on x0..fill_color (latched copies are used).
// - Reset mid-FILL: abort at that edge, no further writes, done never pulses.
// - Arithmetic: coordinate counters are COORD_W unsigned and compare by equality to latched bounds.
// - Counters never exceed WIDTH-1 / HEIGHT-1, so fb addresses stay in range.
// CONFIGURATION
// - FILL_CHECKER_EN defined:
//   - Fill colour = fill_color when (x[0]^y[0])==0, else ~fill_color.
//   - This gives a 1-pixel checkerboard anchored at absolute coordinates.
// - FILL_CHECKER_EN undefined: solid fill_color; no checker logic synthesised.
// STRUCTURE
// - Package fill_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_t
//   - localparam default WIDTH/HEIGHT
//   - function clamp()
// - Sub-module raster_stepper: holds x/y counters.
//   - Loads (x0,y0) on load.
//   - Steps with wrap on step.
//   - Flags last when x==x1c && y==y1c.
// - Top: FSM, input latches, output mux/registers, optional checker logic.
// TESTING
// - Pass-through: IDLE, cl_write=1, (5,7,1) -> fb_x=5, fb_y=7, fb_color=1, fb_write=1 next cycle.
//   - Client write with cl_x=700 -> fb_write=0.
// - Small fill: start, (2,3)-(4,4), colour 1 -> 6 writes in order (2,3)(3,3)(4,3)(2,4)(3,4)(4,4).
//   - busy=1 throughout; done=1 the cycle after (4,4); cl_ready=0 until IDLE.
// - Full screen: (0,0)-(1023,1023), colour 0 -> clamped; exactly 307200 writes; last write (639,479); single done pulse.
// - Empty / degenerate: x0=10, x1=9 -> zero writes, done pulses 1 cycle after start.
//   - Single pixel (8,8)-(8,8) -> one write.
// - Disturbance: re-assert start and change x1 mid-fill -> no restart, original bounds used.
//   - reset_n=0 mid-fill -> fb_write=0 next cycle, busy=0, no done.
// - FILL_CHECKER_EN: (0,0)-(1,1), colour 1 -> colours 1,0,0,1. Without the macro -> all 1.

Source files
------------

// File: rtl/rect_fill_engine_pkg.sv
// Shared types and helpers for the rectangle fill engine.
package fill_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_t;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

    function automatic int clamp(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/rect_fill_engine_raster_stepper.sv
// Raster-order x/y walker: loads a start pixel, steps with row wrap, flags the final pixel.
module raster_stepper #(
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic [COORD_W-1:0] x_wrap,
    input  logic [COORD_W-1:0] x_end,
    input  logic [COORD_W-1:0] y_end,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               last
);

    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;

    assign last = (x_reg == x_end) && (y_reg == y_end);

    always_comb begin
        next_x = x_reg + 1'b1;
        next_y = y_reg;
        if (x_reg == x_end) begin
            next_x = x_wrap;
            next_y = y_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (load) begin
            x_reg <= load_x;
            y_reg <= load_y;
        end else if (step) begin
            x_reg <= next_x;
            y_reg <= next_y;
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine in front of the framebuffer write port; client writes pass through when idle.
// Define FILL_CHECKER_EN for a 1-pixel checkerboard fill instead of a solid colour.
module rect_fill_engine
    import fill_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int COORD_W = 11,
    parameter int COLOR_W = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               busy,
    output logic               done,
    input  logic [COORD_W-1:0] cl_x,
    input  logic [COORD_W-1:0] cl_y,
    input  logic [COLOR_W-1:0] cl_color,
    input  logic               cl_write,
    output logic               cl_ready,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [COLOR_W-1:0] fb_color,
    output logic               fb_write
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

    fill_state_t        state_reg, state_next;
    logic [COORD_W-1:0] x0_reg, x1c_reg, y1c_reg;
    logic [COLOR_W-1:0] color_reg;
    logic [COORD_W-1:0] fb_x_reg, fb_y_reg;
    logic [COLOR_W-1:0] fb_color_reg;
    logic               fb_write_reg, busy_reg, done_reg, cl_ready_reg;

    logic [COORD_W-1:0] x1c_in, y1c_in, next_x, next_y;
    logic [COLOR_W-1:0] first_color, step_color;
    logic               empty_in, last, load, step;

    assign x1c_in   = COORD_W'(clamp(int'(x1), WIDTH - 1));
    assign y1c_in   = COORD_W'(clamp(int'(y1), HEIGHT - 1));
    assign empty_in = (x0 > x1c_in) || (y0 > y1c_in) || (x0 > X_MAX) || (y0 > Y_MAX);

`ifdef FILL_CHECKER_EN
    // Checker parity uses absolute coordinates so adjacent fills tile seamlessly.
    assign first_color = (x0[0] ^ y0[0]) ? ~fill_color : fill_color;
    assign step_color  = (next_x[0] ^ next_y[0]) ? ~color_reg : color_reg;
`else
    assign first_color = fill_color;
    assign step_color  = color_reg;
`endif

    raster_stepper #(.COORD_W(COORD_W)) u_stepper (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .step   (step),
        .load_x (x0),
        .load_y (y0),
        .x_wrap (x0_reg),
        .x_end  (x1c_reg),
        .y_end  (y1c_reg),
        .next_x (next_x),
        .next_y (next_y),
        .last   (last)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            S_IDLE: if (start) begin
                load       = !empty_in;
                state_next = empty_in ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (last) state_next = S_DONE;
                else      step       = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_reg == S_IDLE && start) begin
            x0_reg    <= x0;
            x1c_reg   <= x1c_in;
            y1c_reg   <= y1c_in;
            color_reg <= fill_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            fb_x_reg     <= '0;
            fb_y_reg     <= '0;
            fb_color_reg <= '0;
            fb_write_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cl_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            busy_reg     <= (state_next != S_IDLE);
            done_reg     <= (state_next == S_DONE);
            cl_ready_reg <= (state_next == S_IDLE);
            fb_write_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        // The first fill pixel goes out on the same edge that latches the rectangle.
                        if (!empty_in) begin
                            fb_x_reg     <= x0;
                            fb_y_reg     <= y0;
                            fb_color_reg <= first_color;
                            fb_write_reg <= 1'b1;
                        end
                    end else begin
                        fb_x_reg     <= cl_x;
                        fb_y_reg     <= cl_y;
                        fb_color_reg <= cl_color;
                        fb_write_reg <= cl_write && (cl_x <= X_MAX) && (cl_y <= Y_MAX);
                    end
                end
                S_FILL: if (!last) begin
                    fb_x_reg     <= next_x;
                    fb_y_reg     <= next_y;
                    fb_color_reg <= step_color;
                    fb_write_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fb_x     = fb_x_reg;
    assign fb_y     = fb_y_reg;
    assign fb_color = fb_color_reg;
    assign fb_write = fb_write_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign cl_ready = cl_ready_reg;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine on a reduced 64x48 screen with a behavioural pixel model.
module tb_rect_fill_engine;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int CW = 11;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] x0, y0, x1, y1;
    logic [0:0]    fill_color;
    logic          busy, done;
    logic [CW-1:0] cl_x, cl_y;
    logic [0:0]    cl_color;
    logic          cl_write;
    logic          cl_ready;
    logic [CW-1:0] fb_x, fb_y;
    logic [0:0]    fb_color;
    logic          fb_write;

    pix_t exp_q[$];
    int   exp_done = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rect_fill_engine #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .COLOR_W(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .fill_color(fill_color),
        .busy      (busy),
        .done      (done),
        .cl_x      (cl_x),
        .cl_y      (cl_y),
        .cl_color  (cl_color),
        .cl_write  (cl_write),
        .cl_ready  (cl_ready),
        .fb_x      (fb_x),
        .fb_y      (fb_y),
        .fb_color  (fb_color),
        .fb_write  (fb_write)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int model_color(input int x, input int y, input int c);
`ifdef FILL_CHECKER_EN
        return (((x + y) % 2) == 1) ? 1 - c : c;
`else
        return c;
`endif
    endfunction

    // Monitor: every framebuffer write must match the oldest expected pixel.
    always @(negedge clk) begin
        if (reset_n && fb_write) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fb_write unexpected: got (%0d,%0d,%0d) expected no write", fb_x, fb_y, fb_color);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                if (int'(fb_x) != e.x || int'(fb_y) != e.y || int'(fb_color) != e.c) begin
                    n_fail++;
                    $display("FAIL fb_pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             fb_x, fb_y, fb_color, e.x, e.y, e.c);
                end
            end
        end
        if (reset_n && done) begin
            n_checks++;
            if (exp_done == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got 1 expected 0");
            end else begin
                exp_done--;
            end
        end
    end

    task automatic clear_inputs();
        start = 1'b0; cl_write = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; fill_color = '0;
        cl_x = '0; cl_y = '0; cl_color = '0;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!cl_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("wait_ready", int'(cl_ready), 1);
    endtask

    task automatic client_write(input int x, input int y, input int c);
        @(negedge clk);
        cl_x = CW'(x); cl_y = CW'(y); cl_color = 1'(c); cl_write = 1'b1;
        if (x < W && y < H) exp_q.push_back('{x, y, c});
        @(posedge clk);
        #1;
        check("client_fb_write", int'(fb_write), (x < W && y < H) ? 1 : 0);
        cl_write = 1'b0;
        $display("client write (%0d,%0d) colour %0d", x, y, c);
    endtask

    task automatic do_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int c, input bit disturb, input bit with_cl);
        int x1c, y1c, n, k;
        wait_ready();
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        fill_color = 1'(c); start = 1'b1;
        if (with_cl) begin
            cl_x = CW'(1); cl_y = CW'(1); cl_color = 1'b1; cl_write = 1'b1;
        end
        x1c = (ax1 > W - 1) ? W - 1 : ax1;
        y1c = (ay1 > H - 1) ? H - 1 : ay1;
        n = 0;
        for (int yy = ay0; yy <= y1c; yy++)
            for (int xx = ax0; xx <= x1c; xx++) begin
                exp_q.push_back('{xx, yy, model_color(xx, yy, c)});
                n++;
            end
        exp_done++;
        @(posedge clk);
        #1;
        start = 1'b0; cl_write = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            check("busy_in_fill", int'(busy) * 2 + int'(cl_ready), 2);
            k++;
            if (k > n + 5) begin
                check("done_timeout", k, n);
                break;
            end
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                x0 = CW'($urandom_range(0, 100)); y0 = CW'($urandom_range(0, 100));
                x1 = CW'($urandom_range(0, 100)); y1 = CW'($urandom_range(0, 100));
                fill_color = 1'($urandom_range(0, 1));
                cl_x = CW'($urandom_range(0, W - 1)); cl_y = CW'($urandom_range(0, H - 1));
                cl_color = 1'($urandom_range(0, 1)); cl_write = 1'($urandom_range(0, 1));
            end
        end
        clear_inputs();
        check("done_latency", k, n);
        check("busy_at_done", int'(busy), 1);
        check("queue_empty_at_done", exp_q.size(), 0);
        @(negedge clk);
        check("idle_after_done", int'(busy) * 2 + int'(done) * 4 + int'(cl_ready), 1);
        $display("fill (%0d,%0d)-(%0d,%0d) colour %0d: %0d writes expected, done after %0d cycles",
                 ax0, ay0, ax1, ay1, c, n, k);
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fb_x", int'(fb_x), 0);
        check("rst_fb_y", int'(fb_y), 0);
        check("rst_fb_color", int'(fb_color), 0);
        check("rst_fb_write", int'(fb_write), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cl_ready", int'(cl_ready), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("cl_ready_after_reset", int'(cl_ready), 1);

        client_write(5, 7, 1);
        check("pass_fb_x", int'(fb_x), 5);
        check("pass_fb_y", int'(fb_y), 7);
        check("pass_fb_color", int'(fb_color), 1);
        client_write(700, 3, 1);
        client_write(3, 60, 0);

        do_fill(2, 3, 4, 4, 1, 1'b0, 1'b1);
        do_fill(0, 0, 1023, 1023, 0, 1'b0, 1'b0);
        do_fill(10, 0, 9, 5, 1, 1'b0, 1'b0);
        do_fill(8, 8, 8, 8, 1, 1'b0, 1'b0);
        do_fill(70, 2, 80, 4, 1, 1'b0, 1'b0);
        do_fill(0, 0, 1, 1, 1, 1'b0, 1'b0);
        do_fill(5, 5, 12, 8, 1, 1'b1, 1'b0);

        // Abort a fill with reset; nothing more may be written and done must stay low.
        wait_ready();
        x0 = CW'(0); y0 = CW'(0); x1 = CW'(20); y1 = CW'(20); fill_color = 1'b1; start = 1'b1;
        for (int yy = 0; yy <= 20; yy++)
            for (int xx = 0; xx <= 20; xx++)
                exp_q.push_back('{xx, yy, model_color(xx, yy, 1)});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("abort_fb_write", int'(fb_write), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("fill (0,0)-(20,20) aborted by reset");

        for (int i = 0; i < 20; i++) begin
            int ax0, ay0, ax1, ay1;
            ax0 = $urandom_range(0, W + 4);
            ay0 = $urandom_range(0, H + 4);
            ax1 = ax0 + $urandom_range(0, 10) - 2;
            ay1 = ay0 + $urandom_range(0, 6) - 2;
            if (ax1 < 0) ax1 = 0;
            if (ay1 < 0) ay1 = 0;
            if ($urandom_range(0, 4) == 0) ax1 = 1000;
            do_fill(ax0, ay0, ax1, ay1, $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            client_write($urandom_range(0, W + 10), $urandom_range(0, H + 10), $urandom_range(0, 1));
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_balance", exp_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
